// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin serial adder scheduler.
package adder_sched_pkg;

    // Width of the shared adder slice.
    localparam int SLICE_W = 8;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_RESP
    } sched_state_t;

endpackage

// File: rtl/adder.sv
// 8-bit ripple adder slice shared by all requesters.
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    // Walk from the farthest offset back to ptr so the closest hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler that runs wide additions serially through one 8-bit adder.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// req_ready is a one-hot grant raised only in S_IDLE, and rsp_* stay stable while
// rsp_valid is high until rsp_ready is seen.
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter  int WORDS = 4,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*SLICE_W*WORDS-1:0] req_a,
    input  logic [NREQ*SLICE_W*WORDS-1:0] req_b,
    input  logic [NREQ-1:0]               req_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic [SLICE_W*WORDS-1:0]      rsp_sum,
    output logic                          rsp_cout
);

    localparam int W  = SLICE_W * WORDS;
    localparam int KW = $clog2(WORDS) + 1;

    sched_state_t state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, rsp_sum_q, rsp_sum_d;
    logic           cin_q, cin_d, carry_q, carry_d, rsp_cout_q, rsp_cout_d;
    logic [KW-1:0]  k_q, k_d;

    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [SLICE_W-1:0] add_a, add_b, add_s;
    logic               add_cin, add_cout;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    // Slice mux: feed byte k of the captured operands; slice 0 takes the captured carry-in.
    always_comb begin
        add_a   = a_q[k_q*SLICE_W +: SLICE_W];
        add_b   = b_q[k_q*SLICE_W +: SLICE_W];
        add_cin = (k_q == '0) ? cin_q : carry_q;
    end

    // Next-state and grant logic for the scheduler FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        k_d        = k_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
        req_ready  = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    req_ready = reset ? gnt : '0;
                    a_d       = req_a[gnt_idx*W +: W];
                    b_d       = req_b[gnt_idx*W +: W];
                    cin_d     = req_cin[gnt_idx];
                    id_d      = gnt_idx;
                    ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    k_d       = '0;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                sum_d[k_q*SLICE_W +: SLICE_W] = add_s;
                carry_d = add_cout;
                if (k_q == KW'(WORDS - 1)) begin
                    rsp_sum_d  = sum_d;
                    rsp_cout_d = add_cout;
                    rsp_id_d   = id_q;
                    k_d        = '0;
                    state_d    = S_RESP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            k_q        <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            k_q        <= k_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched with a response scoreboard.
module tb_adder_rr_sched;

    localparam int WORDS = 4;
    localparam int NREQ  = 4;
    localparam int W     = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;

    // Expected entries are {id, cout, sum}.
    logic [W+2:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int grant_cnt = 0;
    int last_gnt = 0;
    int last_ready_cyc = 0;
    int prev_gnt_cyc = 0;
    bit have_prev = 1'b0;
    bit chk_interval = 1'b0;

    adder_rr_sched #(.WORDS(WORDS), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Driver tasks.
    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [W-1:0] sum, input logic cout);
        exp_q.push_back({id, cout, sum});
    endtask

    // Returns #1 after the edge on which the n-th further grant was accepted.
    task automatic wait_grants(input int n);
        int target;
        int budget;
        target = grant_cnt + n;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (grant_cnt < target && budget < 100);
        if (grant_cnt < target) fail_now("grant_timeout");
        #1;
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        set_op(i, a, b, cin);
        req_valid[i] = 1'b1;
        wait_grants(1);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Accept observer: records grants, checks one-hot and accept spacing.
    always @(negedge clk) begin
        if (reset && req_ready != '0) begin
            chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_gnt = i;
            if (chk_interval && have_prev) chk("accept_interval", 64'(cyc - prev_gnt_cyc), 64'(WORDS + 2));
            prev_gnt_cyc   = cyc;
            have_prev      = 1'b1;
            last_ready_cyc = cyc;
            grant_cnt++;
        end
    end

    // Scoreboard monitor: latency, hold stability and result comparison.
    logic         prev_valid = 1'b0;
    logic         held = 1'b0;
    logic [W-1:0] h_sum;
    logic [1:0]   h_id;
    logic         h_cout;
    always @(negedge clk) begin
        logic [W+2:0] e;
        if (rsp_valid) begin
            if (!prev_valid) chk("latency", 64'(cyc - last_ready_cyc), 64'(WORDS + 1));
            if (held) begin
                chk("hold_sum", 64'(rsp_sum), 64'(h_sum));
                chk("hold_id", 64'(rsp_id), 64'(h_id));
                chk("hold_cout", 64'(rsp_cout), 64'(h_cout));
            end
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: got id %0d sum %0h expected no response", rsp_id, rsp_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e[W+2:W+1]));
                    chk("rsp_cout", 64'(rsp_cout), 64'(e[W]));
                    chk("rsp_sum", 64'(rsp_sum), 64'(e[W-1:0]));
                end
                held = 1'b0;
            end else begin
                held   = 1'b1;
                h_sum  = rsp_sum;
                h_id   = rsp_id;
                h_cout = rsp_cout;
            end
        end else begin
            held = 1'b0;
        end
        prev_valid = rsp_valid;
    end

    // Directed test sequence.
    initial begin
        int budget;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests asserted to confirm no grant while in reset.
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_sum", 64'(rsp_sum), 64'd0);
        chk("reset_id", 64'(rsp_id), 64'd0);
        chk("reset_cout", 64'(rsp_cout), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Byte carry into slice 1.
        push_exp(2'd0, 32'h0000_0100, 1'b0);
        issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        drain();

        // Only req3 valid while ptr=1; ptr then wraps to 0.
        push_exp(2'd3, 32'hEFBE_D000, 1'b0);
        issue(3, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
        chk("req3_grant", 64'(last_gnt), 64'd3);
        drain();

        // All requesters held valid: order 0,1,2,3,0 with fixed accept spacing.
        set_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        set_op(1, 32'hF000_0000, 32'h1000_0000, 1'b0);
        set_op(2, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
        set_op(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        push_exp(2'd0, 32'h2345_6789, 1'b0);
        push_exp(2'd1, 32'h0000_0000, 1'b1);
        push_exp(2'd2, 32'h0001_0001, 1'b0);
        push_exp(2'd3, 32'hFFFF_FFFF, 1'b0);
        push_exp(2'd0, 32'h2345_6789, 1'b0);
        have_prev    = 1'b0;
        chk_interval = 1'b1;
        req_valid    = 4'b1111;
        wait_grants(5);
        req_valid    = '0;
        chk_interval = 1'b0;
        drain();

        // Carry ripples through every slice.
        push_exp(2'd1, 32'h0000_0000, 1'b1);
        issue(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drain();

        // Response back-pressure for 10 cycles.
        rsp_ready = 1'b0;
        push_exp(2'd2, 32'h0000_0000, 1'b1);
        issue(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!rsp_valid && budget < 50);
        if (!rsp_valid) fail_now("stall_rsp_timeout");
        @(posedge clk);
        #1;
        set_op(0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        repeat (10) begin
            @(negedge clk);
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        // Reset during slice 2 of a req3 operation.
        set_op(3, 32'h0102_0304, 32'h1020_3040, 1'b0);
        req_valid[3] = 1'b1;
        wait_grants(1);
        req_valid[3] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_op(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        set_op(3, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        push_exp(2'd0, 32'hFFFF_FFFF, 1'b0);
        push_exp(2'd3, 32'h0000_0000, 1'b1);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("inreset_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("abort_valid", 64'(rsp_valid), 64'd0);
        chk("abort_sum", 64'(rsp_sum), 64'd0);
        chk("abort_id", 64'(rsp_id), 64'd0);
        chk("abort_cout", 64'(rsp_cout), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_grants(1);
        chk("post_reset_first", 64'(last_gnt), 64'd0);
        req_valid[0] = 1'b0;
        wait_grants(1);
        chk("post_reset_second", 64'(last_gnt), 64'd3);
        req_valid = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
